// File: rtl/mem_bus_bridge_if.sv
// Signal bundle between a single bus master, the mem_bus_bridge and its slave ports.
// The bridge uses the slave modport; the environment (master plus slave devices) uses the master modport.
interface mem_bus_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 3
);
  logic                             m_req;
  logic                             m_we;
  logic [ADDR_WIDTH-1:0]            m_addr;
  logic [DATA_WIDTH-1:0]            m_wdata;
  logic [DATA_WIDTH-1:0]            m_rdata;
  logic                             m_ready;
  logic                             m_err;
  logic [NUM_SLAVES-1:0]            s_sel;
  logic                             s_we;
  logic [ADDR_WIDTH-1:0]            s_addr;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]            s_ready;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    output m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    input  m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// Single-master to NUM_SLAVES address-decoding bridge with registered one-hot slave select.
// Optional ACCESS-state timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    (NUM_SLAVES*ADDR_WIDTH)'({32'h10010000, 32'h00400000}),
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    (NUM_SLAVES*ADDR_WIDTH)'({32'hFFFFFF00, 32'hFFFF0000}),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_bus_bridge_if.slave bus
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 4) begin : g_bad_num_slaves
    $error("mem_bus_bridge: NUM_SLAVES must be in 1..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_bus_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [NUM_SLAVES-1:0] hit_sel;
  logic [ADDR_WIDTH-1:0] hit_offset;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic                  ready_hit;
  logic                  timeout_hit;

  // Walk from the highest slot down so the lowest matching index is the one left standing.
  // An all-zero mask marks an unpopulated slot (the default packs fewer windows than slots).
  always_comb begin
    hit_sel    = '0;
    hit_offset = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
          ((bus.m_addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_sel    = '0;
        hit_sel[k] = 1'b1;
        hit_offset = bus.m_addr & ~SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Only the selected slave's ready and read data are observed; the others are masked off.
  always_comb begin
    rdata_mux = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q[k]) begin
        rdata_mux = rdata_mux | bus.s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ready_hit = |(bus.s_ready & sel_q);

`ifdef BUS_TIMEOUT_EN
  localparam int CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] wait_cnt;

  // Held at zero outside ACCESS, so every ACCESS entry starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == CntWidth'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.m_req) begin
          state_next = (hit_sel != '0) ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        if (ready_hit) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slave-side request is captured once at accept and frozen until the access ends,
  // which is what makes later master-side changes invisible to the slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m_req && (hit_sel != '0)) begin
            sel_q   <= hit_sel;
            we_q    <= bus.m_we;
            addr_q  <= hit_offset;
            wdata_q <= bus.m_wdata;
            rdata_q <= '0;
          end
        end
        ACCESS: begin
          if (ready_hit) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= we_q ? '0 : rdata_mux;
          end else if (timeout_hit) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.s_sel   = sel_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.m_ready = (state == RESP) || (state == ERR);
  assign bus.m_err   = (state == ERR);
  assign bus.m_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 The block SHALL have parameter NUM_SLAVES, default 3, meaning the number of slave ports (legal range 1..4).
REQ-004 The block SHALL have parameter SLAVE_BASE, default {32'h10010000, 32'h00400000}, meaning the packed base address per slave, slave 0 in the LSBs.
REQ-005 The block SHALL have parameter SLAVE_MASK, default {32'hFFFFFF00, 32'hFFFF0000}, meaning the packed decode mask per slave.
REQ-006 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the ACCESS-state cycles allowed before an error (minimum 2).
REQ-007 The block SHALL have the following ports, one per line as name  direction  width  meaning:
 clk  in  1  single clock; all state updates on the rising edge
 rst  in  1  asynchronous, active-high reset
 m_req  in  1  master request; sampled only in IDLE
 m_we  in  1  1 = write, 0 = read
 m_addr  in  ADDR_WIDTH  byte address
 m_wdata  in  DATA_WIDTH  write data
 m_rdata  out  DATA_WIDTH  read data, valid while m_ready=1
 m_ready  out  1  one-cycle transaction-complete pulse
 m_err  out  1  decode-miss or timeout flag, qualified by m_ready
 s_sel  out  NUM_SLAVES  one-hot slave select
 s_we  out  1  write strobe, valid with s_sel
 s_addr  out  ADDR_WIDTH  offset address (latched addr AND NOT mask)
 s_wdata  out  DATA_WIDTH  latched write data
 s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
 s_ready  in  NUM_SLAVES  slave completion, one bit per slave

Function
REQ-008 The FSM SHALL have the states IDLE, ACCESS, RESP and ERR, and SHALL be in IDLE out of reset.
REQ-009 In IDLE with m_req=1, the block SHALL latch m_we, m_addr and m_wdata, then decode the latched address: slave k matches when (m_addr & MASK[k]) == BASE[k], and the lowest matching index wins.
REQ-010 On a match the block SHALL go to ACCESS and assert s_sel[k] from the following cycle; on no match it SHALL go to ERR.
REQ-011 In ACCESS, s_sel[k], s_we, s_addr and s_wdata SHALL be held stable until the first cycle in which s_ready[k]=1.
REQ-012 In that cycle the block SHALL capture s_rdata slice k and go to RESP; s_ready bits of unselected slaves SHALL be ignored.
REQ-013 RESP SHALL last exactly one cycle with m_ready=1, m_err=0, m_rdata equal to the captured data (0 for writes) and s_sel=0, then return to IDLE.
REQ-014 ERR SHALL last exactly one cycle with m_ready=1, m_err=1, m_rdata=0 and s_sel=0, then return to IDLE.
REQ-015 Minimum latency SHALL be 2 cycles from accept to m_ready: request accepted at edge N, s_sel high in cycle N+1 with s_ready=1, m_ready in cycle N+2.
REQ-016 Changes on m_req, m_addr, m_we and m_wdata after acceptance SHALL be ignored until the block returns to IDLE.
REQ-017 A request held high through RESP SHALL be accepted again only in IDLE, so back-to-back transactions take at least 3 cycles each.
REQ-018 s_sel SHALL be registered, one-hot or zero, and never glitch.

Reset
REQ-019 Asserting rst SHALL immediately force IDLE and set m_ready=0, m_err=0, m_rdata=0, s_sel=0, s_we=0, s_addr=0, s_wdata=0 and the timeout counter to 0, including mid-ACCESS.
REQ-020 The first request SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-021 With BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS, increment each ACCESS cycle, and after TIMEOUT_CYCLES cycles without s_ready[k] the block SHALL drop s_sel and go to ERR.
REQ-022 Without BUS_TIMEOUT_EN, no counter SHALL be synthesised and ACCESS SHALL wait indefinitely for s_ready[k].

Verification
REQ-023 Read of 0x00400008 with slave 0 s_ready=1 immediately -> s_sel=3'b001 one cycle, s_addr=0x8, m_ready with m_rdata equal to the slave 0 data 2 cycles after accept.
REQ-024 Write of 0xDEADBEEF to 0x10010010 with slave 1 s_ready delayed 3 cycles -> s_we=1, s_sel=3'b010 and s_wdata stable for 4 cycles, then m_ready=1 and m_err=0.
REQ-025 Read of 0x20000000 (no match) -> no s_sel asserted, m_ready=1, m_err=1 and m_rdata=0 one cycle after accept.
REQ-026 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, s_ready held 0 -> s_sel drops after 16 ACCESS cycles, then m_err=1 and m_ready=1.
REQ-027 rst pulsed in the 2nd ACCESS cycle -> all outputs 0 asynchronously, and a new request is served normally after release.
REQ-028 m_req held high continuously with s_ready=1 -> one m_ready pulse every 3 cycles, and m_addr changes during ACCESS do not affect s_addr.
